// File: rtl/led_debug_page_mux.sv
// LED test-point pager: debounced per-port page buttons, a clear button, and a
// registered mux that selects one test-point page (or the status page) for the LEDs.
module led_debug_page_mux #(
   parameter int NUM_PORTS       = 3,
   parameter int PAGES           = 4,
   parameter int LED_W           = 8,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int EXCLUSIVE       = 0
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [NUM_PORTS-1:0]                     btn_port,
   input  logic                                     btn_clear,
   input  logic [NUM_PORTS*(PAGES-1)*LED_W-1:0]     test_point,
   input  logic [LED_W-1:0]                         default_page,
   output logic [LED_W-1:0]                         led,
   output logic [$clog2(NUM_PORTS+1)-1:0]           sel_port,
   output logic [$clog2(PAGES)-1:0]                 sel_page
);

   localparam int NB     = NUM_PORTS + 1;
   localparam int SEL_W  = $clog2(NUM_PORTS+1);
   localparam int PAGE_W = $clog2(PAGES);
   localparam int TP_W   = NUM_PORTS*(PAGES-1)*LED_W;
   localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES-1);
   localparam logic [PAGE_W-1:0] PAGE_MAX = PAGE_W'(PAGES-1);

   logic [NB-1:0] raw;
   logic [NB-1:0] db;
   logic [NB-1:0] rel;

   // The clear button rides along as the last conditioning lane.
   assign raw = {btn_clear, btn_port};

   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_btn
         logic            sync_a_reg;
         logic            sync_b_reg;
         logic            db_reg;
         logic            rel_reg;
         logic [DB_W-1:0] dbc_reg;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               sync_a_reg <= 1'b0;
               sync_b_reg <= 1'b0;
               db_reg     <= 1'b0;
               rel_reg    <= 1'b0;
               dbc_reg    <= '0;
            end else begin
               sync_a_reg <= raw[gi];
               sync_b_reg <= sync_a_reg;
               rel_reg    <= 1'b0;
               if (sync_b_reg == db_reg) begin
                  dbc_reg <= '0;
               end else if (dbc_reg == DB_MAX) begin
                  db_reg  <= sync_b_reg;
                  dbc_reg <= '0;
                  // Only a 1->0 accept is a release.
                  rel_reg <= db_reg;
               end else begin
                  dbc_reg <= dbc_reg + 1'b1;
               end
            end
         end

         assign db[gi]  = db_reg;
         assign rel[gi] = rel_reg;
      end
   endgenerate

   logic [PAGE_W-1:0] cnt_reg  [NUM_PORTS];
   logic [PAGE_W-1:0] cnt_next [NUM_PORTS];
   logic              hit;
   int                win;

   function automatic logic [PAGE_W-1:0] page_inc(input logic [PAGE_W-1:0] c);
      return (c == PAGE_MAX) ? '0 : c + 1'b1;
   endfunction

   always_comb begin
      hit = 1'b0;
      win = 0;
      for (int p = 0; p < NUM_PORTS; p++) cnt_next[p] = cnt_reg[p];
      if (db[NUM_PORTS]) begin
         for (int p = 0; p < NUM_PORTS; p++) cnt_next[p] = '0;
      end else if (EXCLUSIVE != 0) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (rel[p] && !hit) begin
               hit = 1'b1;
               win = p;
            end
         end
         if (hit) begin
            for (int p = 0; p < NUM_PORTS; p++)
               cnt_next[p] = (p == win) ? page_inc(cnt_reg[p]) : '0;
         end
      end else begin
         for (int p = 0; p < NUM_PORTS; p++)
            if (rel[p]) cnt_next[p] = page_inc(cnt_reg[p]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int p = 0; p < NUM_PORTS; p++) cnt_reg[p] <= '0;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) cnt_reg[p] <= cnt_next[p];
      end
   end

   logic [TP_W-1:0]   tp_cap_reg;
   logic [LED_W-1:0]  dp_cap_reg;
   logic [LED_W-1:0]  led_next;
   logic [SEL_W-1:0]  sel_port_next;
   logic [PAGE_W-1:0] sel_page_next;

   // Walk from the top port down so the lowest active port has the last word.
   always_comb begin
      sel_port_next = SEL_W'(NUM_PORTS);
      sel_page_next = '0;
      led_next      = dp_cap_reg;
      for (int p = NUM_PORTS-1; p >= 0; p--) begin
         if (cnt_reg[p] != '0) begin
            sel_port_next = SEL_W'(p);
            sel_page_next = cnt_reg[p];
            led_next      = tp_cap_reg[(p*(PAGES-1) + int'(cnt_reg[p]) - 1)*LED_W +: LED_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tp_cap_reg <= '0;
         dp_cap_reg <= '0;
         led        <= '0;
         sel_port   <= SEL_W'(NUM_PORTS);
         sel_page   <= '0;
      end else begin
         tp_cap_reg <= test_point;
         dp_cap_reg <= default_page;
         led        <= led_next;
         sel_port   <= sel_port_next;
         sel_page   <= sel_page_next;
      end
   end

endmodule

// File: tb/tb_led_debug_page_mux.sv
// Randomised bench for led_debug_page_mux: one instance per EXCLUSIVE setting,
// both driven together and compared to a button-event level model.
module tb_led_debug_page_mux;

   localparam int NP = 3;
   localparam int PG = 4;
   localparam int LW = 8;
   localparam int DB = 4;
   localparam int SETTLE = 16;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic [NP-1:0]   btn_port = '0;
   logic            btn_clear = 1'b0;
   logic [71:0]     tp = '0;
   logic [7:0]      dp = '0;
   logic [7:0]      led_o      [2];
   logic [1:0]      sel_port_o [2];
   logic [1:0]      sel_page_o [2];

   int checks = 0;
   int errors = 0;
   int mcnt [2][NP];

   always #5 clk = ~clk;

   led_debug_page_mux #(.NUM_PORTS(NP), .PAGES(PG), .LED_W(LW),
                        .DEBOUNCE_CYCLES(DB), .EXCLUSIVE(0)) u_dut0 (
      .clk(clk), .rst(rst_n), .btn_port(btn_port), .btn_clear(btn_clear),
      .test_point(tp), .default_page(dp),
      .led(led_o[0]), .sel_port(sel_port_o[0]), .sel_page(sel_page_o[0]));

   led_debug_page_mux #(.NUM_PORTS(NP), .PAGES(PG), .LED_W(LW),
                        .DEBOUNCE_CYCLES(DB), .EXCLUSIVE(1)) u_dut1 (
      .clk(clk), .rst(rst_n), .btn_port(btn_port), .btn_clear(btn_clear),
      .test_point(tp), .default_page(dp),
      .led(led_o[1]), .sel_port(sel_port_o[1]), .sel_page(sel_page_o[1]));

   // Reference model: page counters change only on whole button events.
   function automatic int exp_port(input int e);
      for (int p = 0; p < NP; p++) if (mcnt[e][p] != 0) return p;
      return NP;
   endfunction

   function automatic int exp_page(input int e);
      int p;
      p = exp_port(e);
      return (p == NP) ? 0 : mcnt[e][p];
   endfunction

   function automatic logic [7:0] exp_led(input int e);
      int p;
      p = exp_port(e);
      if (p == NP) return dp;
      return tp[(p*(PG-1) + mcnt[e][p] - 1)*LW +: LW];
   endfunction

   task automatic model_rel(input logic [NP-1:0] m);
      for (int p = 0; p < NP; p++) if (m[p]) mcnt[0][p] = (mcnt[0][p] + 1) % PG;
      for (int p = 0; p < NP; p++) begin
         if (m[p]) begin
            for (int q = 0; q < NP; q++) mcnt[1][q] = (q == p) ? (mcnt[1][q] + 1) % PG : 0;
            break;
         end
      end
   endtask

   task automatic model_clear();
      for (int e = 0; e < 2; e++) for (int p = 0; p < NP; p++) mcnt[e][p] = 0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic [NP-1:0] m, input int hold);
      btn_port = m;
      tick(hold);
      btn_port = '0;
      tick(SETTLE);
      model_rel(m);
   endtask

   task automatic clear_pulse();
      btn_clear = 1'b1;
      tick(8);
      btn_clear = 1'b0;
      tick(SETTLE);
      model_clear();
   endtask

   task automatic test_reset();
      tp = {$urandom, $urandom, $urandom};
      dp = 8'hA5;
      #3 rst_n = 1'b0;
      #1;
      for (int e = 0; e < 2; e++) begin
         checks++;
         if (led_o[e] !== 8'h00 || sel_port_o[e] !== 2'd3 || sel_page_o[e] !== 2'd0) begin
            errors++;
            $display("FAIL reset_hold dut%0d got led=%h port=%0d page=%0d want 00/3/0",
                     e, led_o[e], sel_port_o[e], sel_page_o[e]);
         end
      end
      tick(3);
      rst_n = 1'b1;
      model_clear();
      tick(1);
      for (int e = 0; e < 2; e++) begin
         checks++;
         if (led_o[e] !== 8'h00) begin
            errors++;
            $display("FAIL reset_first_cycle dut%0d led got %h want 00", e, led_o[e]);
         end
      end
      tick(1);
      for (int e = 0; e < 2; e++) begin
         checks++;
         if (led_o[e] !== 8'hA5 || sel_port_o[e] !== 2'd3 || sel_page_o[e] !== 2'd0) begin
            errors++;
            $display("FAIL reset_default dut%0d got led=%h port=%0d page=%0d want a5/3/0",
                     e, led_o[e], sel_port_o[e], sel_page_o[e]);
         end
      end
      $display("txn reset: default page a5 after release");
   endtask

   task automatic test_page_cycle();
      tp[((1*(PG-1)) + 2 - 1)*LW +: LW] = 8'h3C;
      for (int n = 1; n <= 4; n++) begin
         press(3'b010, 5 + n);
         for (int e = 0; e < 2; e++) begin
            checks++;
            if (led_o[e] !== exp_led(e) || sel_port_o[e] !== 2'(exp_port(e))
                || sel_page_o[e] !== 2'(exp_page(e))) begin
               errors++;
               $display("FAIL page_cycle%0d dut%0d got led=%h port=%0d page=%0d want %h/%0d/%0d",
                        n, e, led_o[e], sel_port_o[e], sel_page_o[e],
                        exp_led(e), exp_port(e), exp_page(e));
            end
         end
         if (n == 2) begin
            checks++;
            if (led_o[0] !== 8'h3C || sel_page_o[0] !== 2'd2) begin
               errors++;
               $display("FAIL page2_literal led got %h page %0d want 3c/2", led_o[0], sel_page_o[0]);
            end
         end
         $display("txn page_cycle: release %0d on port 1, page now %0d", n, exp_page(0));
      end
   endtask

   task automatic test_glitch();
      press(3'b100, 7);
      btn_port = 3'b001;
      tick(8);
      btn_port = 3'b000;
      tick(2);
      btn_port = 3'b001;
      tick(SETTLE);
      for (int e = 0; e < 2; e++) begin
         checks++;
         if (led_o[e] !== exp_led(e) || sel_port_o[e] !== 2'(exp_port(e))
             || sel_page_o[e] !== 2'(exp_page(e))) begin
            errors++;
            $display("FAIL glitch_hold dut%0d got led=%h port=%0d page=%0d want %h/%0d/%0d",
                     e, led_o[e], sel_port_o[e], sel_page_o[e], exp_led(e), exp_port(e), exp_page(e));
         end
      end
      btn_port = 3'b000;
      tick(SETTLE);
      model_rel(3'b001);
      for (int e = 0; e < 2; e++) begin
         checks++;
         if (led_o[e] !== exp_led(e) || sel_port_o[e] !== 2'(exp_port(e))
             || sel_page_o[e] !== 2'(exp_page(e))) begin
            errors++;
            $display("FAIL glitch_release dut%0d got led=%h port=%0d page=%0d want %h/%0d/%0d",
                     e, led_o[e], sel_port_o[e], sel_page_o[e], exp_led(e), exp_port(e), exp_page(e));
         end
      end
      $display("txn glitch: 2-cycle dropout on port 0 ignored, single release counted");
   endtask

   task automatic test_exclusive();
      clear_pulse();
      press(3'b100, 6);
      press(3'b001, 6);
      checks++;
      if (sel_port_o[0] !== 2'd0 || sel_port_o[1] !== 2'd0) begin
         errors++;
         $display("FAIL lowest_wins got ports %0d/%0d want 0/0", sel_port_o[0], sel_port_o[1]);
      end
      for (int k = 0; k < 3; k++) press(3'b001, 6);
      for (int e = 0; e < 2; e++) begin
         checks++;
         if (led_o[e] !== exp_led(e) || sel_port_o[e] !== 2'(exp_port(e))
             || sel_page_o[e] !== 2'(exp_page(e))) begin
            errors++;
            $display("FAIL exclusive_wrap dut%0d got led=%h port=%0d page=%0d want %h/%0d/%0d",
                     e, led_o[e], sel_port_o[e], sel_page_o[e], exp_led(e), exp_port(e), exp_page(e));
         end
      end
      press(3'b110, 7);
      for (int e = 0; e < 2; e++) begin
         checks++;
         if (led_o[e] !== exp_led(e) || sel_port_o[e] !== 2'(exp_port(e))
             || sel_page_o[e] !== 2'(exp_page(e))) begin
            errors++;
            $display("FAIL simultaneous dut%0d got led=%h port=%0d page=%0d want %h/%0d/%0d",
                     e, led_o[e], sel_port_o[e], sel_page_o[e], exp_led(e), exp_port(e), exp_page(e));
         end
      end
      $display("txn exclusive: port 2 kept in shared mode, cleared in exclusive mode");
   endtask

   task automatic test_clear_same_cycle();
      press(3'b001, 6);
      btn_port = 3'b001;
      tick(8);
      btn_port = 3'b000;
      btn_clear = 1'b1;
      tick(8);
      btn_clear = 1'b0;
      tick(SETTLE);
      model_clear();
      for (int e = 0; e < 2; e++) begin
         checks++;
         if (led_o[e] !== dp || sel_port_o[e] !== 2'd3 || sel_page_o[e] !== 2'd0) begin
            errors++;
            $display("FAIL clear_vs_rel dut%0d got led=%h port=%0d page=%0d want %h/3/0",
                     e, led_o[e], sel_port_o[e], sel_page_o[e], dp);
         end
      end
      $display("txn clear: clear beats same-cycle port 0 release");
   endtask

   task automatic test_reset_mid();
      clear_pulse();
      for (int k = 0; k < 3; k++) press(3'b010, 6);
      checks++;
      if (sel_port_o[1] !== 2'd1 || sel_page_o[1] !== 2'd3) begin
         errors++;
         $display("FAIL pre_reset_page got port=%0d page=%0d want 1/3", sel_port_o[1], sel_page_o[1]);
      end
      btn_port = 3'b010;
      tick(4);
      #2 rst_n = 1'b0;
      #1;
      for (int e = 0; e < 2; e++) begin
         checks++;
         if (led_o[e] !== 8'h00 || sel_port_o[e] !== 2'd3 || sel_page_o[e] !== 2'd0) begin
            errors++;
            $display("FAIL async_reset dut%0d got led=%h port=%0d page=%0d want 00/3/0",
                     e, led_o[e], sel_port_o[e], sel_page_o[e]);
         end
      end
      tick(2);
      rst_n = 1'b1;
      model_clear();
      tick(SETTLE);
      for (int e = 0; e < 2; e++) begin
         checks++;
         if (led_o[e] !== dp || sel_port_o[e] !== 2'd3 || sel_page_o[e] !== 2'd0) begin
            errors++;
            $display("FAIL no_spurious_rel dut%0d got led=%h port=%0d page=%0d want %h/3/0",
                     e, led_o[e], sel_port_o[e], sel_page_o[e], dp);
         end
      end
      btn_port = 3'b000;
      tick(SETTLE);
      model_rel(3'b010);
      for (int e = 0; e < 2; e++) begin
         checks++;
         if (led_o[e] !== exp_led(e) || sel_port_o[e] !== 2'(exp_port(e))
             || sel_page_o[e] !== 2'(exp_page(e))) begin
            errors++;
            $display("FAIL held_through_reset dut%0d got led=%h port=%0d page=%0d want %h/%0d/%0d",
                     e, led_o[e], sel_port_o[e], sel_page_o[e], exp_led(e), exp_port(e), exp_page(e));
         end
      end
      $display("txn reset_mid: async reset mid-debounce, held button gives one release");
   endtask

   task automatic test_random();
      int op;
      logic [NP-1:0] m;
      for (int i = 0; i < 40; i++) begin
         op = $urandom_range(0, 4);
         case (op)
            0, 1: begin
               m = 3'b001 << $urandom_range(0, NP-1);
               press(m, $urandom_range(6, 10));
            end
            2: begin
               m = 3'($urandom_range(1, 7));
               press(m, $urandom_range(6, 10));
            end
            3: begin
               tp = {$urandom, $urandom, $urandom};
               dp = 8'($urandom);
               m = '0;
               tick(2);
            end
            default: begin
               m = '0;
               clear_pulse();
            end
         endcase
         for (int e = 0; e < 2; e++) begin
            checks++;
            if (led_o[e] !== exp_led(e) || sel_port_o[e] !== 2'(exp_port(e))
                || sel_page_o[e] !== 2'(exp_page(e))) begin
               errors++;
               $display("FAIL random%0d dut%0d got led=%h port=%0d page=%0d want %h/%0d/%0d",
                        i, e, led_o[e], sel_port_o[e], sel_page_o[e],
                        exp_led(e), exp_port(e), exp_page(e));
            end
         end
         $display("txn random %0d: op=%0d mask=%b -> port %0d/%0d page %0d/%0d",
                  i, op, m, exp_port(0), exp_port(1), exp_page(0), exp_page(1));
      end
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_clear();
      test_reset();
      test_page_cycle();
      test_glitch();
      test_exclusive();
      test_clear_same_cycle();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
